alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 121 ++++++++++++
 tb/tb_alu_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for one shared combinational ALU.
// One operation in flight: accept, execute for a cycle, hold the result.
module alu_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ALU_CTRL_WIDTH = 5,
   parameter logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_NOP = '0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req0_valid,
   output logic                      req0_ready,
   input  logic [ALU_CTRL_WIDTH-1:0] req0_ctrl,
   input  logic [DATA_WIDTH-1:0]     req0_src1,
   input  logic [DATA_WIDTH-1:0]     req0_src2,
   input  logic                      req1_valid,
   output logic                      req1_ready,
   input  logic [ALU_CTRL_WIDTH-1:0] req1_ctrl,
   input  logic [DATA_WIDTH-1:0]     req1_src1,
   input  logic [DATA_WIDTH-1:0]     req1_src2,
   output logic                      rsp0_valid,
   input  logic                      rsp0_ready,
   output logic [DATA_WIDTH-1:0]     rsp0_result,
   output logic                      rsp0_take_branch,
   output logic                      rsp1_valid,
   input  logic                      rsp1_ready,
   output logic [DATA_WIDTH-1:0]     rsp1_result,
   output logic                      rsp1_take_branch,
   output logic [ALU_CTRL_WIDTH-1:0] alu_ctrl,
   output logic [DATA_WIDTH-1:0]     alu_src1,
   output logic [DATA_WIDTH-1:0]     alu_src2,
   input  logic [DATA_WIDTH-1:0]     alu_result,
   input  logic                      alu_take_branch,
   output logic                      busy
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   state_t                    state;
   logic                      last_grant;
   logic                      owner;
   logic [ALU_CTRL_WIDTH-1:0] lat_ctrl;
   logic [DATA_WIDTH-1:0]     lat_src1;
   logic [DATA_WIDTH-1:0]     lat_src2;
   logic                      rsp_done;

   // A port loses only a tie, and only when it was the one served last.
   assign req0_ready = (state == IDLE) && (!req1_valid || last_grant);
   assign req1_ready = (state == IDLE) && (!req0_valid || !last_grant);

   assign alu_ctrl = (state == EXEC) ? lat_ctrl : ALU_CTRL_NOP;
   assign alu_src1 = (state == EXEC) ? lat_src1 : '0;
   assign alu_src2 = (state == EXEC) ? lat_src2 : '0;
   assign busy     = (state != IDLE);
   assign rsp_done = owner ? rsp1_ready : rsp0_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         last_grant       <= 1'b1;
         owner            <= 1'b0;
         lat_ctrl         <= ALU_CTRL_NOP;
         lat_src1         <= '0;
         lat_src2         <= '0;
         rsp0_valid       <= 1'b0;
         rsp0_result      <= '0;
         rsp0_take_branch <= 1'b0;
         rsp1_valid       <= 1'b0;
         rsp1_result      <= '0;
         rsp1_take_branch <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               unique case (1'b1)
                  req0_valid && req0_ready: begin
                     lat_ctrl   <= req0_ctrl;
                     lat_src1   <= req0_src1;
                     lat_src2   <= req0_src2;
                     owner      <= 1'b0;
                     last_grant <= 1'b0;
                     state      <= EXEC;
                  end
                  req1_valid && req1_ready: begin
                     lat_ctrl   <= req1_ctrl;
                     lat_src1   <= req1_src1;
                     lat_src2   <= req1_src2;
                     owner      <= 1'b1;
                     last_grant <= 1'b1;
                     state      <= EXEC;
                  end
                  default: state <= IDLE;
               endcase
            end
            EXEC: begin
               if (owner) begin
                  rsp1_valid       <= 1'b1;
                  rsp1_result      <= alu_result;
                  rsp1_take_branch <= alu_take_branch;
               end else begin
                  rsp0_valid       <= 1'b1;
                  rsp0_result      <= alu_result;
                  rsp0_take_branch <= alu_take_branch;
               end
               state <= RESP;
            end
            RESP: begin
               if (rsp_done) begin
                  rsp0_valid <= 1'b0;
                  rsp1_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction model checked every cycle,
// plus directed operations with hand-computed results.
module tb_alu_arbiter;

   localparam logic [4:0] NOP  = 5'b00000;
   localparam logic [4:0] ADD  = 5'b00000;
   localparam logic [4:0] SUB  = 5'b01000;
   localparam logic [4:0] SLL  = 5'b00001;
   localparam logic [4:0] SLTU = 5'b00011;
   localparam logic [4:0] XORO = 5'b00100;
   localparam logic [4:0] SRA  = 5'b01101;
   localparam logic [4:0] ORO  = 5'b00110;
   localparam logic [4:0] BEQ  = 5'b10000;
   localparam logic [4:0] BLT  = 5'b10100;
   localparam logic [4:0] BGEU = 5'b10111;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [4:0]  req0_ctrl, req1_ctrl;
   logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
   logic        rsp0_valid, rsp0_ready, rsp0_take_branch;
   logic        rsp1_valid, rsp1_ready, rsp1_take_branch;
   logic [31:0] rsp0_result, rsp1_result;
   logic [4:0]  alu_ctrl;
   logic [31:0] alu_src1, alu_src2, alu_result;
   logic        alu_take_branch, busy;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   alu_arbiter dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_ctrl(req0_ctrl), .req0_src1(req0_src1), .req0_src2(req0_src2),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_ctrl(req1_ctrl), .req1_src1(req1_src1), .req1_src2(req1_src2),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp0_result(rsp0_result), .rsp0_take_branch(rsp0_take_branch),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp1_result(rsp1_result), .rsp1_take_branch(rsp1_take_branch),
      .alu_ctrl(alu_ctrl), .alu_src1(alu_src1), .alu_src2(alu_src2),
      .alu_result(alu_result), .alu_take_branch(alu_take_branch),
      .busy(busy)
   );

   function automatic logic [31:0] alu_res(logic [4:0] c, logic [31:0] a, logic [31:0] b);
      if (c[4]) return 32'h0;
      case (c[2:0])
         3'd0: return c[3] ? a - b : a + b;
         3'd1: return a << b[4:0];
         3'd2: return {31'h0, $signed(a) < $signed(b)};
         3'd3: return {31'h0, a < b};
         3'd4: return a ^ b;
         3'd5: return c[3] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'd6: return a | b;
         default: return a & b;
      endcase
   endfunction

   function automatic logic alu_br(logic [4:0] c, logic [31:0] a, logic [31:0] b);
      if (!c[4]) return 1'b0;
      case (c[2:0])
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return $signed(a) < $signed(b);
         3'd5: return $signed(a) >= $signed(b);
         3'd6: return a < b;
         3'd7: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   assign alu_result      = alu_res(alu_ctrl, alu_src1, alu_src2);
   assign alu_take_branch = alu_br(alu_ctrl, alu_src1, alu_src2);

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction model: an accepted op ages from execute into a held response.
   bit          m_init = 0;
   bit          m_busy, m_last, m_owner;
   int          m_age;
   logic [4:0]  m_ctrl;
   logic [31:0] m_s1, m_s2, m_res;
   logic        m_br;
   bit          e_rv [2];
   logic [31:0] e_rr [2];
   logic        e_rb [2];

   always @(posedge clk) begin
      int g;
      if (rst) begin
         m_init = 1; m_busy = 0; m_last = 1; m_owner = 0; m_age = 0;
         for (int i = 0; i < 2; i++) begin
            e_rv[i] = 0; e_rr[i] = 0; e_rb[i] = 0;
         end
      end else if (m_init) begin
         if (!m_busy) begin
            g = -1;
            if (req0_valid && (!req1_valid || m_last)) g = 0;
            else if (req1_valid) g = 1;
            if (g >= 0) begin
               m_busy = 1; m_age = 0; m_owner = g[0]; m_last = g[0];
               m_ctrl = g[0] ? req1_ctrl : req0_ctrl;
               m_s1   = g[0] ? req1_src1 : req0_src1;
               m_s2   = g[0] ? req1_src2 : req0_src2;
               m_res  = alu_res(m_ctrl, m_s1, m_s2);
               m_br   = alu_br(m_ctrl, m_s1, m_s2);
            end
         end else if (m_age == 0) begin
            m_age = 1;
            e_rv[m_owner] = 1; e_rr[m_owner] = m_res; e_rb[m_owner] = m_br;
         end else if (m_owner ? rsp1_ready : rsp0_ready) begin
            m_busy = 0;
            e_rv[m_owner] = 0;
         end
      end
   end

   always @(negedge clk) begin
      bit ex;
      if (m_init) begin
         ex = m_busy && m_age == 0;
         chk("cyc_req0_ready", req0_ready, !m_busy && (!req1_valid || m_last));
         chk("cyc_req1_ready", req1_ready, !m_busy && (!req0_valid || !m_last));
         chk("cyc_busy", busy, m_busy);
         chk("cyc_alu_ctrl", alu_ctrl, ex ? m_ctrl : NOP);
         chk("cyc_alu_src1", alu_src1, ex ? m_s1 : 32'h0);
         chk("cyc_alu_src2", alu_src2, ex ? m_s2 : 32'h0);
         chk("cyc_rsp0_valid", rsp0_valid, e_rv[0]);
         chk("cyc_rsp1_valid", rsp1_valid, e_rv[1]);
         chk("cyc_rsp0_result", rsp0_result, e_rr[0]);
         chk("cyc_rsp1_result", rsp1_result, e_rr[1]);
         chk("cyc_rsp0_br", rsp0_take_branch, e_rb[0]);
         chk("cyc_rsp1_br", rsp1_take_branch, e_rb[1]);
      end
   end

   task automatic drive(input bit p, input logic v, input logic [4:0] c,
                        input logic [31:0] a, input logic [31:0] b);
      if (p) begin
         req1_valid = v; req1_ctrl = c; req1_src1 = a; req1_src2 = b;
      end else begin
         req0_valid = v; req0_ctrl = c; req0_src1 = a; req0_src2 = b;
      end
   endtask

   // Single request with response ready: result visible two cycles after accept.
   task automatic op(input bit p, input logic [4:0] c, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] r, input logic br,
                     input string nm);
      @(posedge clk); #1;
      drive(p, 1'b1, c, a, b);
      @(posedge clk); #1;
      drive(p, 1'b0, c, a, b);
      @(negedge clk);
      chk({nm, "_exec_valid"}, p ? rsp1_valid : rsp0_valid, 1'b0);
      @(negedge clk);
      chk({nm, "_valid"}, p ? rsp1_valid : rsp0_valid, 1'b1);
      chk({nm, "_other"}, p ? rsp0_valid : rsp1_valid, 1'b0);
      chk({nm, "_result"}, p ? rsp1_result : rsp0_result, r);
      chk({nm, "_br"}, p ? rsp1_take_branch : rsp0_take_branch, br);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] ord;
      int         nresp;
      rst = 1'b1;
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      drive(0, 1'b0, NOP, 0, 0);
      drive(1, 1'b0, NOP, 0, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("idle_alu_ctrl", alu_ctrl, NOP);
      chk("idle_alu_src1", alu_src1, 32'h0);
      chk("idle_alu_src2", alu_src2, 32'h0);
      chk("reset_busy", busy, 1'b0);

      op(0, ADD, 32'd10, 32'd20, 32'h1E, 1'b0, "add");

      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      drive(0, 1'b1, SUB, 32'd50, 32'd20);
      drive(1, 1'b1, XORO, 32'hAAAA5555, 32'hFFFF0000);
      ord = '0;
      nresp = 0;
      repeat (12) begin
         @(negedge clk);
         if (rsp0_valid) begin
            chk("tie_sub_result", rsp0_result, 32'h1E);
            ord = {ord[2:0], 1'b0};
            nresp++;
         end
         if (rsp1_valid) begin
            chk("tie_xor_result", rsp1_result, 32'h55555555);
            ord = {ord[2:0], 1'b1};
            nresp++;
         end
      end
      chk("tie_resp_count", nresp, 4);
      chk("tie_order", ord, 4'b0101);
      @(posedge clk); #1;
      drive(0, 1'b0, NOP, 0, 0);
      drive(1, 1'b0, NOP, 0, 0);

      rsp1_ready = 1'b0;
      drive(1, 1'b1, BEQ, 32'hA5A5A5A5, 32'hA5A5A5A5);
      @(posedge clk); #1;
      drive(1, 1'b0, BEQ, 0, 0);
      drive(0, 1'b1, ADD, 32'd1, 32'd2);
      @(negedge clk);
      repeat (5) begin
         @(negedge clk);
         chk("hold_valid", rsp1_valid, 1'b1);
         chk("hold_br", rsp1_take_branch, 1'b1);
         chk("hold_ready0", req0_ready, 1'b0);
         chk("hold_ready1", req1_ready, 1'b0);
         chk("hold_busy", busy, 1'b1);
      end
      @(posedge clk); #1;
      rsp1_ready = 1'b1;
      drive(0, 1'b0, NOP, 0, 0);
      @(negedge clk);
      chk("consume_ready0", req0_ready, 1'b0);
      @(posedge clk); #1;

      drive(0, 1'b1, SRA, 32'hFFFFFF80, 32'd4);
      @(posedge clk); #1;
      drive(0, 1'b0, ADD, 32'h0, 32'h0);
      @(negedge clk);
      chk("sra_latched_src1", alu_src1, 32'hFFFFFF80);
      chk("sra_latched_ctrl", alu_ctrl, SRA);
      @(negedge clk);
      chk("sra_valid", rsp0_valid, 1'b1);
      chk("sra_result", rsp0_result, 32'hFFFFFFF8);

      @(posedge clk); #1;
      drive(1, 1'b1, ADD, 32'd5, 32'd6);
      @(posedge clk); #1;
      drive(1, 1'b0, ADD, 0, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_rsp1_valid", rsp1_valid, 1'b0);
      chk("abort_rsp0_result", rsp0_result, 32'h0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_alu_ctrl", alu_ctrl, NOP);
      @(negedge clk);
      chk("abort_no_resp", rsp1_valid, 1'b0);
      @(posedge clk); #1;
      drive(0, 1'b1, ADD, 32'd3, 32'd4);
      drive(1, 1'b1, ADD, 32'd7, 32'd8);
      @(negedge clk);
      chk("abort_tie_ready0", req0_ready, 1'b1);
      chk("abort_tie_ready1", req1_ready, 1'b0);
      @(posedge clk); #1;
      drive(0, 1'b0, NOP, 0, 0);
      drive(1, 1'b0, NOP, 0, 0);
      repeat (3) @(posedge clk);

      op(1, SLTU, 32'd1, 32'hFFFFFFFF, 32'd1, 1'b0, "sltu");
      op(0, BLT, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b1, "blt");
      op(1, BGEU, 32'd1, 32'hFFFFFFFF, 32'h0, 1'b0, "bgeu");
      op(1, ORO, 32'hF0F00000, 32'h0F0F00FF, 32'hFFFF00FF, 1'b0, "or");
      op(0, SLL, 32'd1, 32'd31, 32'h80000000, 1'b0, "sll");

      repeat (3) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
